// File: rtl/mblock_pkg.sv
// Shared definitions for the micro-op block datapath: immediate extension modes
// and default operand/immediate widths.
package mblock_pkg;

   localparam int unsigned EXT_ZERO  = 32'd0;
   localparam int unsigned EXT_SIGN  = 32'd1;
   localparam int unsigned EXT_UPPER = 32'd2;
   localparam int unsigned EXT_PASS  = 32'd3;

   localparam int unsigned MB_DATA_W = 32'd32;
   localparam int unsigned MB_IMM_W  = 32'd16;

endpackage : mblock_pkg

// File: rtl/mconst_ext.sv
// Combinational immediate extender: widens in[IMM_W-1:0] to DATA_W bits
// according to the compile-time extension mode.
module mconst_ext
   import mblock_pkg::*;
#(
   parameter int unsigned DATA_W   = MB_DATA_W,
   parameter int unsigned IMM_W    = MB_IMM_W,
   parameter int unsigned EXT_MODE = EXT_ZERO
) (
   input  logic [DATA_W-1:0] in,
   output logic [DATA_W-1:0] out
);

   generate
      if (IMM_W == DATA_W) begin : g_full_width
         // No padding bits exist, so every mode degenerates to a straight pass.
         assign out = in;
      end else begin : g_extend
         localparam int unsigned PAD_W = DATA_W - IMM_W;

         logic [DATA_W-1:0] w_ext;

         // Select the extension form for the configured mode.
         always_comb begin
            w_ext = in;
            case (EXT_MODE)
               EXT_ZERO:  w_ext = {{PAD_W{1'b0}}, in[IMM_W-1:0]};
               EXT_SIGN:  w_ext = {{PAD_W{in[IMM_W-1]}}, in[IMM_W-1:0]};
               EXT_UPPER: w_ext = {in[IMM_W-1:0], {PAD_W{1'b0}}};
               EXT_PASS:  w_ext = in;
               default:   w_ext = in;
            endcase
         end

         assign out = w_ext;
      end
   endgenerate

endmodule : mconst_ext

// File: rtl/mconst.sv
// Constant/immediate generator: combinational extended constant for the ALU
// operand muxes plus an ld-strobed registered copy for pipelined consumers.
module mconst
   import mblock_pkg::*;
#(
   parameter int unsigned DATA_W   = MB_DATA_W,
   parameter int unsigned IMM_W    = MB_IMM_W,
   parameter int unsigned EXT_MODE = EXT_ZERO
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in,
   input  logic              ld,
   output logic [DATA_W-1:0] out,
   output logic [DATA_W-1:0] out_q,
   output logic              out_vld
);

   generate
      if ((IMM_W > DATA_W) || (IMM_W == 32'd0) || (EXT_MODE > EXT_PASS)) begin : g_bad_param
         $error("mconst: illegal parameters DATA_W=%0d IMM_W=%0d EXT_MODE=%0d",
                DATA_W, IMM_W, EXT_MODE);
      end
   endgenerate

   logic [DATA_W-1:0] w_ext;
   logic [DATA_W-1:0] r_q;
   logic              r_vld;

   mconst_ext #(
      .DATA_W   (DATA_W),
      .IMM_W    (IMM_W),
      .EXT_MODE (EXT_MODE)
   ) u_ext (
      .in  (in),
      .out (w_ext)
   );

   // Capture register; plain async clear so the first ld after release is taken
   // on the very next rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q   <= {DATA_W{1'b0}};
         r_vld <= 1'b0;
      end else if (ld) begin
         r_q   <= w_ext;
         r_vld <= 1'b1;
      end else begin
         r_q   <= r_q;
         r_vld <= r_vld;
      end
   end

   assign out     = w_ext;
   assign out_q   = r_q;
   assign out_vld = r_vld;

endmodule : mconst

// File: tb/tb_mconst.sv
// Self-checking bench for mconst: one instance per extension mode, directed
// literal checks plus randomized traffic against a behavioural reference model.
module tb_mconst;

   logic        clk;
   logic        clk_en;
   logic        rst_n;
   logic [31:0] in_w;
   logic        ld;
   logic        chk_en;

   logic [31:0] out_a [4];
   logic [31:0] q_a   [4];
   logic        vld_a [4];

   logic [31:0] m_q   [4];
   logic        m_vld;

   int checks;
   int errors;

   for (genvar m = 0; m < 4; m++) begin : g_dut
      mconst #(
         .DATA_W   (32),
         .IMM_W    (16),
         .EXT_MODE (m)
      ) u_dut (
         .clk     (clk),
         .rst_n   (rst_n),
         .in      (in_w),
         .ld      (ld),
         .out     (out_a[m]),
         .out_q   (q_a[m]),
         .out_vld (vld_a[m])
      );
   end

   // Clock toggles only while enabled so early checks run with clk idle.
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   // Reference: extension by arithmetic on the 16-bit immediate value.
   function automatic logic [31:0] ext_model(input int mode, input logic [31:0] v);
      logic [15:0] imm;
      int          s;
      imm = v[15:0];
      s   = int'($signed(imm));
      case (mode)
         0:       return v % 32'd65536;
         1:       return 32'(s);
         2:       return v * 32'd65536;
         3:       return v;
         default: return 32'h0000_0000;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Registered-copy model: a capture on ld, cleared immediately by reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) m_q[k] <= 32'h0000_0000;
         m_vld <= 1'b0;
      end else if (ld) begin
         for (int k = 0; k < 4; k++) m_q[k] <= ext_model(k, in_w);
         m_vld <= 1'b1;
      end
   end

   // Cycle compare process, sampled on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 4; k++) begin
            check($sformatf("out_m%0d", k), out_a[k], ext_model(k, in_w));
            check($sformatf("out_q_m%0d", k), q_a[k], m_q[k]);
            check($sformatf("out_vld_m%0d", k), {31'd0, vld_a[k]}, {31'd0, m_vld});
         end
      end
   end

   initial begin
      clk    = 1'b0;
      clk_en = 1'b0;
      chk_en = 1'b0;
      rst_n  = 1'b0;
      ld     = 1'b0;
      in_w   = 32'h0000_0000;
      checks = 0;
      errors = 0;

      // Clock idle, reset held: combinational path only.
      in_w = 32'h0000_2F12;
      #10;
      check("t1_zero", out_a[0], 32'h0000_2F12);
      check("reset_q", q_a[0], 32'h0000_0000);
      check("reset_vld", {31'd0, vld_a[0]}, 32'h0000_0000);

      in_w = 32'h0000_9618;
      #1;
      check("t2_zero_no_sign", out_a[0], 32'h0000_9618);
      check("t3_sign", out_a[1], 32'hFFFF_9618);
      check("t3_upper", out_a[2], 32'h9618_0000);
      check("t3_pass", out_a[3], 32'h0000_9618);
      in_w = 32'hDEAD_2F12;
      #1;
      check("t2_zero_discard", out_a[0], 32'h0000_2F12);
      check("t2_pass_full", out_a[3], 32'hDEAD_2F12);

      // Release reset with the clock still low, then capture one value.
      rst_n  = 1'b1;
      in_w   = 32'h0000_1234;
      ld     = 1'b1;
      #1;
      clk_en = 1'b1;
      @(posedge clk);
      #1;
      ld   = 1'b0;
      check("t4_q", q_a[0], 32'h0000_1234);
      check("t4_vld", {31'd0, vld_a[0]}, 32'h0000_0001);
      check("t4_q_upper", q_a[2], 32'h1234_0000);
      in_w = 32'h0000_8765;
      @(posedge clk);
      #1;
      check("t4_hold", q_a[0], 32'h0000_1234);
      check("t4_hold_sign", q_a[1], 32'h0000_1234);

      // Reset between edges clears at once; ld is ignored while held.
      rst_n = 1'b0;
      ld    = 1'b1;
      #1;
      check("t5_q_clr", q_a[0], 32'h0000_0000);
      check("t5_vld_clr", {31'd0, vld_a[0]}, 32'h0000_0000);
      in_w = 32'hABCD_8001;
      #1;
      check("t5_out_track", out_a[0], 32'h0000_8001);
      check("t5_out_sign", out_a[1], 32'hFFFF_8001);
      @(posedge clk);
      #1;
      check("t5_ld_ignored", {31'd0, vld_a[0]}, 32'h0000_0000);
      ld    = 1'b0;
      rst_n = 1'b1;

      // Randomized traffic with a reset pulse in the middle.
      @(negedge clk);
      chk_en = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         #1;
         in_w  = $urandom;
         ld    = 1'($urandom_range(0, 1));
         rst_n = (i == 500) ? 1'b0 : 1'b1;
      end
      @(negedge clk);
      chk_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mconst
